dsp_post_adder: RTL and testbench

DSP_POST_ADDER -- requirements
Module: dsp_post_adder

---
 rtl/dsp_pkg.sv | 56 +++++
 rtl/dsp_areg_stage.sv | 30 +++
 rtl/dsp_post_adder.sv | 131 +++++++++++++
 tb/tb_dsp_post_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared DSP post-adder definitions: widths, opmode field layout, mux encodings
// and the 49-bit add/subtract used by the post-adder.
package dsp_pkg;

    localparam int unsigned P_W      = 48;
    localparam int unsigned M_W      = 36;
    localparam int unsigned OPMODE_W = 8;
    localparam int unsigned SUM_W    = P_W + 1;

    // Opmode field positions
    localparam int unsigned OPM_X_LSB   = 0;
    localparam int unsigned OPM_Z_LSB   = 2;
    localparam int unsigned OPM_CY_BIT  = 5;
    localparam int unsigned OPM_SUB_BIT = 7;

    typedef enum logic [1:0] {
        X_ZERO = 2'd0,
        X_M    = 2'd1,
        X_P    = 2'd2,
        X_DAB  = 2'd3
    } x_sel_e;

    typedef enum logic [1:0] {
        Z_ZERO = 2'd0,
        Z_PCIN = 2'd1,
        Z_P    = 2'd2,
        Z_C    = 2'd3
    } z_sel_e;

    typedef struct packed {
        logic   sub;
        logic   rsvd6;
        logic   carry;
        logic   rsvd4;
        z_sel_e z_sel;
        x_sel_e x_sel;
    } opmode_t;

    // Bit 48 of the result is the carry on add and the borrow on subtract.
    function automatic logic [SUM_W-1:0] post_add(
        input logic           sub,
        input logic [P_W-1:0] z,
        input logic [P_W-1:0] x,
        input logic           cy
    );
        logic [SUM_W-1:0] zx;
        logic [SUM_W-1:0] xc;
        zx = {1'b0, z};
        xc = {1'b0, x} + SUM_W'(cy);
        if (sub) begin
            return zx - xc;
        end
        return zx + xc;
    endfunction

endpackage

// File: rtl/dsp_areg_stage.sv
// Optional pipeline register with clock enable and async active-low clear;
// collapses to a wire when BYPASS is set.
module dsp_areg_stage #(
    parameter int unsigned W      = 1,
    parameter bit          BYPASS = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (BYPASS) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, ce};
            assign q = d;
        end else begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (ce) begin
                    q <= d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dsp_post_adder.sv
// DSP post-adder: X/Z operand muxes, 48-bit add/subtract with carry-in,
// optional opmode/carry-in/P/carry-out registers and P feedback for accumulate.
module dsp_post_adder
    import dsp_pkg::*;
#(
    parameter int unsigned OPMODEREG   = 1,
    parameter int unsigned CARRYINREG  = 1,
    parameter int unsigned PREG        = 1,
    parameter int unsigned CARRYOUTREG = 1,
    parameter              CARRYINSEL  = "OPMODE5"
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ce_opmode,
    input  logic                ce_carryin,
    input  logic                ce_p,
    input  logic                ce_carryout,
    input  logic [OPMODE_W-1:0] opmode,
    input  logic [M_W-1:0]      m_in,
    input  logic [P_W-1:0]      dab_in,
    input  logic [P_W-1:0]      c_in,
    input  logic [P_W-1:0]      pcin,
    input  logic                carryin,
    output logic [P_W-1:0]      p,
    output logic [P_W-1:0]      pcout,
    output logic                carryout,
    output logic                carryoutf
);

    logic [OPMODE_W-1:0] opmode_q;
    opmode_t             opm;
    logic                cy_src;
    logic                cy_q;
    logic [P_W-1:0]      p_fb;
    logic [P_W-1:0]      x_val;
    logic [P_W-1:0]      z_val;
    logic [SUM_W-1:0]    sum;

    dsp_areg_stage #(
        .W      (OPMODE_W),
        .BYPASS (OPMODEREG == 0)
    ) u_opmode_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce_opmode),
        .d     (opmode),
        .q     (opmode_q)
    );

    assign opm = opmode_t'(opmode_q);

    // Carry source is taken from the raw opmode so its latency follows CARRYINREG.
    generate
        if (CARRYINSEL == "OPMODE5") begin : g_cy_opmode
            assign cy_src = opmode[OPM_CY_BIT];
        end else begin : g_cy_pin
            assign cy_src = carryin;
        end
    endgenerate

    dsp_areg_stage #(
        .W      (1),
        .BYPASS (CARRYINREG == 0)
    ) u_carryin_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce_carryin),
        .d     (cy_src),
        .q     (cy_q)
    );

    // Without a P register the feedback path reads zero to avoid a loop.
    generate
        if (PREG != 0) begin : g_fb_reg
            assign p_fb = p;
        end else begin : g_fb_zero
            assign p_fb = '0;
        end
    endgenerate

    always_comb begin
        x_val = '0;
        z_val = '0;
        case (opm.x_sel)
            X_ZERO:  x_val = '0;
            X_M:     x_val = P_W'(m_in);
            X_P:     x_val = p_fb;
            X_DAB:   x_val = dab_in;
            default: x_val = '0;
        endcase
        case (opm.z_sel)
            Z_ZERO:  z_val = '0;
            Z_PCIN:  z_val = pcin;
            Z_P:     z_val = p_fb;
            Z_C:     z_val = c_in;
            default: z_val = '0;
        endcase
    end

    assign sum = post_add(opm.sub, z_val, x_val, cy_q);

    dsp_areg_stage #(
        .W      (P_W),
        .BYPASS (PREG == 0)
    ) u_p_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce_p),
        .d     (sum[P_W-1:0]),
        .q     (p)
    );

    dsp_areg_stage #(
        .W      (1),
        .BYPASS (CARRYOUTREG == 0)
    ) u_carryout_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (ce_carryout),
        .d     (sum[P_W]),
        .q     (carryout)
    );

    assign pcout     = p;
    assign carryoutf = carryout;

    logic unused_in;
    assign unused_in = &{1'b0, opm.rsvd4, opm.rsvd6, opm.carry,
                         opmode[OPM_CY_BIT], carryin};

endmodule

// File: tb/tb_dsp_post_adder.sv
// Bench for dsp_post_adder: three configurations driven in parallel and
// compared against a cycle-level arithmetic reference model.
module tb_dsp_post_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce_opmode, ce_carryin, ce_p, ce_carryout;
    logic [7:0]  opmode;
    logic [35:0] m_in;
    logic [47:0] dab_in, c_in, pcin;
    logic        carryin;

    logic [47:0] p0, pcout0, p1, pcout1, p2, pcout2;
    logic        co0, cof0, co1, cof1, co2, cof2;

    int vectors = 0;
    int errs    = 0;

    // Reference state for the fully registered and the P-only configurations
    logic [7:0]  m_op0 = '0;
    logic        m_cy0 = 1'b0;
    logic [47:0] m_p0  = '0;
    logic        m_co0 = 1'b0;
    logic [47:0] m_p2  = '0;
    logic        m_co2 = 1'b0;

    always #5 clk = ~clk;

    dsp_post_adder u_dut0 (
        .clk(clk), .rst_n(rst_n), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin),
        .ce_p(ce_p), .ce_carryout(ce_carryout), .opmode(opmode), .m_in(m_in),
        .dab_in(dab_in), .c_in(c_in), .pcin(pcin), .carryin(carryin),
        .p(p0), .pcout(pcout0), .carryout(co0), .carryoutf(cof0)
    );

    dsp_post_adder #(
        .OPMODEREG(0), .CARRYINREG(0), .PREG(0), .CARRYOUTREG(0), .CARRYINSEL("CARRYIN")
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin),
        .ce_p(ce_p), .ce_carryout(ce_carryout), .opmode(opmode), .m_in(m_in),
        .dab_in(dab_in), .c_in(c_in), .pcin(pcin), .carryin(carryin),
        .p(p1), .pcout(pcout1), .carryout(co1), .carryoutf(cof1)
    );

    dsp_post_adder #(
        .OPMODEREG(0), .CARRYINREG(0), .PREG(1), .CARRYOUTREG(1)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin),
        .ce_p(ce_p), .ce_carryout(ce_carryout), .opmode(opmode), .m_in(m_in),
        .dab_in(dab_in), .c_in(c_in), .pcin(pcin), .carryin(carryin),
        .p(p2), .pcout(pcout2), .carryout(co2), .carryoutf(cof2)
    );

    // Behavioural adder: pick operands by select code, then plain 49-bit arithmetic.
    function automatic logic [48:0] ref_sum(input logic [7:0] op, input logic cy,
                                            input logic [47:0] fb);
        logic [47:0] x, z;
        case (op[1:0])
            2'd0: x = 48'd0;
            2'd1: x = {12'd0, m_in};
            2'd2: x = fb;
            default: x = dab_in;
        endcase
        case (op[3:2])
            2'd0: z = 48'd0;
            2'd1: z = pcin;
            2'd2: z = fb;
            default: z = c_in;
        endcase
        if (op[7]) return {1'b0, z} - {1'b0, x} - {48'd0, cy};
        return {1'b0, z} + {1'b0, x} + {48'd0, cy};
    endfunction

    task automatic model_clear();
        m_op0 = '0; m_cy0 = 1'b0; m_p0 = '0; m_co0 = 1'b0;
        m_p2  = '0; m_co2 = 1'b0;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [48:0] r1;
        r1 = ref_sum(opmode, carryin, 48'd0);
        check("p0", p0, m_p0);
        check("pcout0", pcout0, m_p0);
        check("co0", {47'd0, co0}, {47'd0, m_co0});
        check("cof0", {47'd0, cof0}, {47'd0, m_co0});
        check("p1", p1, r1[47:0]);
        check("pcout1", pcout1, r1[47:0]);
        check("co1", {47'd0, co1}, {47'd0, r1[48]});
        check("cof1", {47'd0, cof1}, {47'd0, r1[48]});
        check("p2", p2, m_p2);
        check("pcout2", pcout2, m_p2);
        check("co2", {47'd0, co2}, {47'd0, m_co2});
        check("cof2", {47'd0, cof2}, {47'd0, m_co2});
    endtask

    // Advance one clock: update the models from the values present at the edge.
    task automatic step();
        logic [48:0] r0, r2;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            r0 = ref_sum(m_op0, m_cy0, m_p0);
            r2 = ref_sum(opmode, opmode[5], m_p2);
            if (ce_opmode)   m_op0 = opmode;
            if (ce_carryin)  m_cy0 = opmode[5];
            if (ce_p)        m_p0  = r0[47:0];
            if (ce_carryout) m_co0 = r0[48];
            if (ce_p)        m_p2  = r2[47:0];
            if (ce_carryout) m_co2 = r2[48];
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        {ce_opmode, ce_carryin, ce_p, ce_carryout} = 4'hF;
        opmode  = 8'h0D;
        m_in    = 36'd100;
        c_in    = 48'd5;
        dab_in  = 48'h1234_5678_9ABC;
        pcin    = 48'h0000_0F0F_0F0F;
        carryin = 1'b0;

        // Reset holds every registered output at zero despite live operands
        repeat (2) step();
        check("rst_p0", p0, 48'd0);
        check("rst_co0", {47'd0, co0}, 48'd0);
        check("rst_p2", p2, 48'd0);

        // X=M, Z=C: result two edges after opmode takes effect
        rst_n = 1'b1;
        step();
        step();
        check("add_105", p0, 48'd105);
        check("add_co", {47'd0, co0}, 48'd0);

        // Subtract with borrow
        opmode = 8'h8D; m_in = 36'd10; c_in = 48'd3;
        step();
        step();
        check("sub_p", p0, 48'hFFFF_FFFF_FFF9);
        check("sub_borrow", {47'd0, co0}, 48'd1);

        // Accumulate from a fresh clear
        opmode = 8'h09; m_in = 36'd7;
        rst_n = 1'b0;
        #1 model_clear();
        step();
        rst_n = 1'b1;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            check("acc", p0, 48'(7 * k));
        end
        ce_p = 1'b0;
        step();
        check("acc_hold", p0, 48'd28);
        ce_p = 1'b1;

        // Reset pulse between edges mid-accumulate
        #2 rst_n = 1'b0;
        #1 model_clear();
        check("rst_async_p0", p0, 48'd0);
        check("rst_async_p2", p2, 48'd0);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_p2", p2, 48'd7);

        // Wrap on X=DAB, Z=C with all-ones operand
        opmode = 8'h0F; dab_in = 48'hFFFF_FFFF_FFFF; c_in = 48'd1; carryin = 1'b0;
        step();
        step();
        check("wrap_p0", p0, 48'd0);
        check("wrap_co0", {47'd0, co0}, 48'd1);
        c_in = 48'd0; carryin = 1'b1;
        #1;
        check("wrap_cyin_p1", p1, 48'd0);
        check("wrap_cyin_co1", {47'd0, co1}, 48'd1);
        step();

        // Without a P register the feedback selects read zero
        opmode = 8'h0A; m_in = 36'd55; carryin = 1'b0;
        #1;
        check("nofb_p1", p1, 48'd0);
        step();

        // Randomised operands, opmodes, enables and occasional resets
        for (int i = 0; i < 300; i++) begin
            opmode  = 8'($urandom);
            m_in    = {4'($urandom), 32'($urandom)};
            dab_in  = {16'($urandom), 32'($urandom)};
            c_in    = {16'($urandom), 32'($urandom)};
            pcin    = {16'($urandom), 32'($urandom)};
            carryin = 1'($urandom);
            {ce_opmode, ce_carryin, ce_p, ce_carryout} = 4'($urandom);
            rst_n   = ($urandom_range(0, 39) != 0);
            if (!rst_n) #1 model_clear();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
